// File: rtl/prng_feed_arbiter.sv
// Round-robin arbiter that hands a shared PRNG to one of three consumers
// for a burst of FEED_CYCLES valid words, optionally extended by lock.
module prng_feed_arbiter #(
    parameter int unsigned FEED_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] lock,
    input  logic       prng_valid,
    output logic       prng_en,
    output logic [2:0] gnt,
    output logic [2:0] en_feed,
    output logic [2:0] done,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FEED = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(FEED_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;

    logic [1:0] cand0, cand1, cand2;
    logic [1:0] win_idx;
    logic       in_feed;

    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        return 3'b001 << i;
    endfunction

    // Search order starts just after the last served requester.
    assign cand0 = next_idx(ptr_q);
    assign cand1 = next_idx(cand0);
    assign cand2 = next_idx(cand1);

    always_comb begin
        win_idx = cand2;
        if (req[cand0]) begin
            win_idx = cand0;
        end else if (req[cand1]) begin
            win_idx = cand1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_FEED;
                    idx_d   = win_idx;
                    gnt_d   = onehot(win_idx);
                    cnt_d   = 8'd0;
                end else begin
                    gnt_d   = 3'b000;
                end
            end
            S_FEED: begin
                // A dropped request wins over a burst ending this cycle.
                if (!req[idx_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = 3'b000;
                    ptr_d   = idx_q;
                    cnt_d   = 8'd0;
                end else if (prng_valid) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = 8'd0;
                        if (!lock[idx_q]) begin
                            state_d = S_DONE;
                            gnt_d   = 3'b000;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = idx_q;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 3'b000;
            cnt_q   <= 8'd0;
            ptr_q   <= 2'd2;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign in_feed = (state_q == S_FEED);
    assign prng_en = in_feed;
    assign gnt     = gnt_q;
    assign en_feed = in_feed ? (gnt_q & {3{prng_valid}}) : 3'b000;
    assign done    = (state_q == S_DONE) ? onehot(idx_q) : 3'b000;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_prng_feed_arbiter.sv
// Bench for prng_feed_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_prng_feed_arbiter;

    localparam int FC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] lock = 3'b000;
    logic       prng_valid = 1'b0;
    logic       prng_en;
    logic [2:0] gnt;
    logic [2:0] en_feed;
    logic [2:0] done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    prng_feed_arbiter #(.FEED_CYCLES(FC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lock       (lock),
        .prng_valid (prng_valid),
        .prng_en    (prng_en),
        .gnt        (gnt),
        .en_feed    (en_feed),
        .done       (done),
        .busy       (busy)
    );

    // Model: phase 0 idle, 1 feeding owner, 2 reporting done.
    int m_phase = 0;
    int m_owner = 0;
    int m_words = 0;
    int m_last  = 2;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_words = 0;
            m_last  = 2;
        end else if (m_phase == 0) begin
            bit found;
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_phase = 1;
                    m_words = 0;
                end
            end
        end else if (m_phase == 1) begin
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_phase = 0;
            end else if (prng_valid) begin
                m_words++;
                if (m_words == FC) begin
                    m_words = 0;
                    if (!lock[m_owner]) m_phase = 2;
                end
            end
        end else begin
            m_last  = m_owner;
            m_phase = 0;
        end
    end

    function automatic logic [10:0] model_out();
        logic [2:0] oh;
        logic [2:0] g, d, e;
        oh = 3'(1 << m_owner);
        g = (m_phase == 1) ? oh : 3'b000;
        d = (m_phase == 2) ? oh : 3'b000;
        e = (m_phase == 1 && prng_valid) ? oh : 3'b000;
        return {g, d, e, (m_phase == 1), (m_phase != 0)};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if ($isunknown(gnt) || $countones(gnt) > 1) begin
                n_fail++;
                $display("FAIL onehot_gnt: gnt=%b, required at most one bit set", gnt);
            end
            n_tests++;
            if (m_phase != 1 && en_feed !== 3'b000) begin
                n_fail++;
                $display("FAIL en_feed_outside_feed: en_feed=%b, required 000", en_feed);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b111;
        lock = 3'b111;
        prng_valid = 1'b1;
        tick();
        tick();
        mon_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({gnt, done, en_feed, prng_en, busy} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b done=%b en_feed=%b prng_en=%b busy=%b, required all 0",
                     gnt, done, en_feed, prng_en, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_first_priority: gnt=%b, required 001", gnt);
        end
        req = 3'b000;
        lock = 3'b000;
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [4];
        logic [2:0] exp_seq [4];
        logic [2:0] prev;
        int ng, pulses, ndone;
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        prev = 3'b000;
        ng = 0;
        pulses = 0;
        ndone = 0;
        do_reset();
        req = 3'b111;
        lock = 3'b000;
        prng_valid = 1'b1;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            @(negedge clk);
            if (gnt != 3'b000 && prev == 3'b000) begin
                seq[ng] = gnt;
                ng++;
            end
            if (en_feed != 3'b000) pulses++;
            if (done != 3'b000) begin
                n_tests++;
                if (pulses != FC || ng == 0 || done !== seq[(ng > 0) ? ng - 1 : 0]) begin
                    n_fail++;
                    $display("FAIL rr_burst: done=%b after %0d en_feed, required %0d words then done of last grant",
                             done, pulses, FC);
                end
                pulses = 0;
                ndone++;
            end
            prev = gnt;
            tick();
        end
        n_tests++;
        if (ng != 4 || ndone != 3) begin
            n_fail++;
            $display("FAIL rr_count: grants=%0d dones=%0d, required 4 and 3", ng, ndone);
        end
        for (int i = 0; i < ng; i++) begin
            n_tests++;
            if (seq[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: gnt=%b, required %b", i, seq[i], exp_seq[i]);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_stall_toggle();
        int fc, pulses, ndone;
        logic [2:0] dval;
        fc = 0;
        pulses = 0;
        ndone = 0;
        dval = 3'b000;
        do_reset();
        req = 3'b010;
        lock = 3'b000;
        prng_valid = 1'b0;
        tick();
        for (int c = 0; c < 30; c++) begin
            prng_valid = (c % 2 == 0);
            @(negedge clk);
            if (prng_en) fc++;
            if (en_feed[1]) pulses++;
            if (done != 3'b000) begin
                ndone++;
                dval = done;
                req = 3'b000;
            end
            tick();
        end
        n_tests++;
        if (fc != 7 || pulses != 4) begin
            n_fail++;
            $display("FAIL stall_counts: feed_cycles=%0d pulses=%0d, required 7 and 4", fc, pulses);
        end
        n_tests++;
        if (ndone != 1 || dval !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_done: done_cycles=%0d done=%b, required 1 cycle of 010", ndone, dval);
        end
        prng_valid = 1'b0;
    endtask

    task automatic test_lock_extend();
        int pulses, ndone, bad;
        logic [2:0] dval;
        pulses = 0;
        ndone = 0;
        bad = 0;
        dval = 3'b000;
        do_reset();
        req = 3'b100;
        lock = 3'b100;
        prng_valid = 1'b1;
        tick();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (en_feed[2]) pulses++;
            if (prng_en && gnt !== 3'b100) bad++;
            if (done != 3'b000) begin
                ndone++;
                dval = done;
                req = 3'b000;
            end
            if (pulses >= 6) lock = 3'b000;
            tick();
        end
        n_tests++;
        if (pulses != 2 * FC || bad != 0) begin
            n_fail++;
            $display("FAIL lock_pulses: pulses=%0d bad_gnt=%0d, required %0d and 0", pulses, bad, 2 * FC);
        end
        n_tests++;
        if (ndone != 1 || dval !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_done: done_cycles=%0d done=%b, required 1 cycle of 100", ndone, dval);
        end
    endtask

    task automatic test_abort();
        int pulses;
        pulses = 0;
        do_reset();
        req = 3'b011;
        lock = 3'b000;
        prng_valid = 1'b1;
        tick();
        for (int c = 0; c < 10 && pulses < 2; c++) begin
            @(negedge clk);
            if (en_feed[0]) pulses++;
            tick();
        end
        req = 3'b010;
        prng_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pulses != 2 || gnt !== 3'b001 || en_feed !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_pre: pulses=%0d gnt=%b en_feed=%b, required 2, 001, 000", pulses, gnt, en_feed);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b000 || done !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: gnt=%b done=%b busy=%b, required 000 000 0", gnt, done, busy);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b010 || done !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_next: gnt=%b done=%b, required 010 000", gnt, done);
        end
        req = 3'b000;
    endtask

    task automatic test_reset_mid_feed();
        do_reset();
        req = 3'b001;
        lock = 3'b000;
        prng_valid = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b110;
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b000 || prng_en !== 1'b0 || busy !== 1'b0 || en_feed !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset: gnt=%b prng_en=%b busy=%b en_feed=%b, required 000 0 0 000",
                     gnt, prng_en, busy, en_feed);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL midreset_regrant: gnt=%b, required 010", gnt);
        end
        req = 3'b000;
    endtask

    task automatic test_random();
        logic [10:0] exp_v;
        logic [10:0] got_v;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) lock = 3'($urandom_range(0, 7));
            prng_valid = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            exp_v = model_out();
            got_v = {gnt, done, en_feed, prng_en, busy};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: gnt/done/en_feed/prng_en/busy=%b, required %b", c, got_v, exp_v);
            end
            tick();
        end
        rst = 1'b0;
        req = 3'b000;
        lock = 3'b000;
    endtask

    initial begin
        #1;
        test_reset();
        test_round_robin();
        test_stall_toggle();
        test_lock_extend();
        test_abort();
        test_reset_mid_feed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
